// File: rtl/lr_car_detector.sv
`default_nettype none
// ============================================================================
// Module      : lr_car_detector
// Description : Local-road loop-sensor front end. It synchronizes and
//               debounces the arrival and departure loops, then keeps a
//               saturating count of the cars queued on the local road.
// Revision    : 1.0 - initial release
// ============================================================================
module lr_car_detector #(
    parameter int DEBOUNCE = 4,
    parameter int QUEUE_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arrive_raw,
    input  logic               depart_raw,
    output logic               lr_has_car,
    output logic [QUEUE_W-1:0] car_count,
    output logic               overflow,
    output logic               underflow
);

    localparam int                 c_CNT_W     = $clog2(DEBOUNCE);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DEBOUNCE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [QUEUE_W-1:0] c_COUNT_MAX = '1;

    localparam logic [1:0] c_ST_LOW      = 2'd0;
    localparam logic [1:0] c_ST_RISE_CHK = 2'd1;
    localparam logic [1:0] c_ST_HIGH     = 2'd2;
    localparam logic [1:0] c_ST_FALL_CHK = 2'd3;

    // Channel 0 is the arrival loop, channel 1 the departure loop.
    logic [1:0] w_raw;
    logic [1:0] w_evt;

    assign w_raw = {depart_raw, arrive_raw};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic               r_s1;
            logic               r_s2;
            logic [1:0]         r_state;
            logic [1:0]         w_state_nxt;
            logic [c_CNT_W-1:0] r_cnt;
            logic [c_CNT_W-1:0] w_cnt_nxt;
            logic               r_evt;
            logic               w_evt_nxt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_state <= c_ST_LOW;
                    r_cnt   <= '0;
                    r_evt   <= 1'b0;
                end else begin
                    r_s1    <= w_raw[g];
                    r_s2    <= r_s1;
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_evt   <= w_evt_nxt;
                end
            end

            // Event fires only on the accepted rising edge, never on a fall.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_evt_nxt   = 1'b0;
                case (r_state)
                    c_ST_LOW: begin
                        if (r_s2) begin
                            w_state_nxt = c_ST_RISE_CHK;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                    c_ST_RISE_CHK: begin
                        if (!r_s2) begin
                            w_state_nxt = c_ST_LOW;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_state_nxt = c_ST_HIGH;
                            w_evt_nxt   = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_HIGH: begin
                        if (!r_s2) begin
                            w_state_nxt = c_ST_FALL_CHK;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                    c_ST_FALL_CHK: begin
                        if (r_s2) begin
                            w_state_nxt = c_ST_HIGH;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_state_nxt = c_ST_LOW;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = c_ST_LOW;
                    end
                endcase
            end

            assign w_evt[g] = r_evt;
        end
    endgenerate

    logic [QUEUE_W-1:0] r_count;
    logic [QUEUE_W-1:0] w_count_nxt;
    logic               r_has_car;
    logic               r_ovf;
    logic               r_unf;
    logic               w_ovf_set;
    logic               w_unf_set;

    // Simultaneous arrival and departure cancel out, even at the limits.
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (w_evt)
            2'b01: begin
                if (r_count == c_COUNT_MAX) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_count_nxt = r_count + QUEUE_W'(1);
                end
            end
            2'b10: begin
                if (r_count == '0) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_count_nxt = r_count - QUEUE_W'(1);
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // lr_has_car is taken from the next count so it tracks car_count exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_has_car <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_has_car <= (w_count_nxt != '0);
            r_ovf     <= r_ovf | w_ovf_set;
            r_unf     <= r_unf | w_unf_set;
        end
    end

    assign car_count  = r_count;
    assign lr_has_car = r_has_car;
    assign overflow   = r_ovf;
    assign underflow  = r_unf;

endmodule
`default_nettype wire
